fd_prog: RTL and testbench

- Programmable, parametrised successor to the fixed divide-by-2 frequency divider used in the DLL clock path.
- Divides clk by a run-time ratio N (2..2^W-1) with near-50% duty cycle.
- Applies ratio changes glitch-free at period boundaries through a load/busy handshake.
- Provides a period-start tick and a current-ratio readback for the DLL control loop.

---
 rtl/fd_pkg.sv | 13 +
 rtl/fd_period_cnt.sv | 65 ++++++
 rtl/fd_prog.sv | 84 ++++++++
 tb/tb_fd_prog.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared constants and helpers for the programmable DLL clock divider.
// The high-phase length is computed one bit wider than the ratio to avoid overflow.
package fd_pkg;

   localparam int FD_W_DEFAULT = 8;
   localparam int FD_MIN_RATIO = 2;
   localparam int FD_MAXW      = 32;

   function automatic logic [FD_MAXW:0] fd_high_len(input logic [FD_MAXW-1:0] n);
      return ({1'b0, n} + (FD_MAXW+1)'(1)) >> 1;
   endfunction

endpackage

// File: rtl/fd_period_cnt.sv
// Period counter and duty compare for fd_prog.
// All state changes on the falling edge of clk.
module fd_period_cnt
   import fd_pkg::*;
#(
   parameter int   W          = FD_W_DEFAULT,
   parameter logic INIT_LEVEL = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] ratio,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         div_out,
   output logic         div_tick
);

   logic [W-1:0]     cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;
   logic [FD_MAXW:0] high_len;

   assign high_len = fd_high_len(FD_MAXW'(ratio));
   assign wrap     = en && run_q && (cnt_q == ratio - W'(1));

   always_comb begin
      cnt_d  = cnt_q;
      run_d  = run_q;
      out_d  = out_q;
      tick_d = tick_q;
      if (!en) begin
         cnt_d  = '0;
         run_d  = 1'b0;
         out_d  = INIT_LEVEL;
         tick_d = 1'b0;
      end else begin
         // first enabled edge restarts the period at cnt=0 instead of advancing
         run_d  = 1'b1;
         cnt_d  = (!run_q || wrap) ? '0 : cnt_q + W'(1);
         tick_d = (cnt_d == '0);
         out_d  = ((FD_MAXW+1)'(cnt_d) < high_len) ? INIT_LEVEL : ~INIT_LEVEL;
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         run_q  <= 1'b0;
         out_q  <= INIT_LEVEL;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign cnt      = cnt_q;
   assign div_out  = out_q;
   assign div_tick = tick_q;

endmodule

// File: rtl/fd_prog.sv
// Programmable clock divider with glitch-free ratio updates at period boundaries.
// Holds the pending ratio, load/busy handshake and rejected-load error pulse.
module fd_prog
   import fd_pkg::*;
#(
   parameter int   W           = FD_W_DEFAULT,
   parameter int   DIV_DEFAULT = 2,
   parameter logic INIT_LEVEL  = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] div_ratio,
   input  logic         div_load,
   output logic         div_busy,
   output logic         div_err,
   output logic         div_out,
   output logic         div_tick,
   output logic [W-1:0] div_cur
);

   logic [W-1:0] cur_q, cur_d;
   logic [W-1:0] pend_q, pend_d;
   logic         busy_q, busy_d;
   logic         err_q, err_d;
   logic         wrap;
   logic         load_ok;
   logic [W-1:0] cnt_unused;

   fd_period_cnt #(
      .W          (W),
      .INIT_LEVEL (INIT_LEVEL)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .ratio    (cur_q),
      .cnt      (cnt_unused),
      .wrap     (wrap),
      .div_out  (div_out),
      .div_tick (div_tick)
   );

   assign load_ok = div_ratio >= W'(FD_MIN_RATIO);

   always_comb begin
      cur_d  = cur_q;
      pend_d = pend_q;
      busy_d = busy_q;
      err_d  = 1'b0;
      if (busy_q && (wrap || !en)) begin
         cur_d  = pend_q;
         busy_d = 1'b0;
      end
      // a load on the apply edge is kept for the following boundary
      if (div_load) begin
         if (load_ok) begin
            pend_d = div_ratio;
            busy_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         cur_q  <= W'(DIV_DEFAULT);
         pend_q <= W'(DIV_DEFAULT);
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cur_q  <= cur_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign div_cur  = cur_q;
   assign div_busy = busy_q;
   assign div_err  = err_q;

endmodule

// File: tb/tb_fd_prog.sv
// Scoreboard bench for fd_prog: directed scenarios then random traffic.
// Expected outputs come from a period-level reference model.
module tb_fd_prog;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] div_ratio = '0;
   logic         div_load = 1'b0;
   logic         div_busy;
   logic         div_err;
   logic         div_out;
   logic         div_tick;
   logic [W-1:0] div_cur;

   fd_prog #(
      .W           (W),
      .DIV_DEFAULT (2),
      .INIT_LEVEL  (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .div_ratio (div_ratio),
      .div_load  (div_load),
      .div_busy  (div_busy),
      .div_err   (div_err),
      .div_out   (div_out),
      .div_tick  (div_tick),
      .div_cur   (div_cur)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         out;
      logic         tick;
      logic         busy;
      logic         err;
      logic [W-1:0] cur;
   } exp_t;

   exp_t sb[$];
   int   vecs = 0;
   int   bad  = 0;
   int   cyc_no = 0;

   // reference model: position inside the current period plus ratio bookkeeping
   int m_pos, m_cur, m_pend;
   bit m_busy, m_run;

   task automatic cyc(input bit rst, input bit e, input bit ld, input int r);
      exp_t x;
      bit   bnd;
      @(posedge clk);
      rst_n     = !rst;
      en        = e;
      div_load  = ld;
      div_ratio = W'(r);
      if (rst) begin
         m_pos  = 0;
         m_cur  = 2;
         m_pend = 2;
         m_busy = 0;
         m_run  = 0;
         x.out  = 1'b1;
         x.tick = 1'b0;
         x.err  = 1'b0;
      end else begin
         bnd = e && m_run && (m_pos == m_cur - 1);
         if (!e) begin
            m_pos = 0;
            m_run = 0;
         end else if (!m_run) begin
            m_pos = 0;
            m_run = 1;
         end else begin
            m_pos = (m_pos + 1) % m_cur;
         end
         if (m_busy && (bnd || !e)) begin
            m_cur  = m_pend;
            m_busy = 0;
         end
         x.err = ld && (r < 2);
         if (ld && r >= 2) begin
            m_pend = r;
            m_busy = 1;
         end
         x.out  = !e ? 1'b1 : (2 * m_pos < m_cur);
         x.tick = e && (m_pos == 0);
      end
      x.busy = m_busy;
      x.cur  = W'(m_cur);
      sb.push_back(x);
   endtask

   initial begin
      forever begin
         exp_t x;
         exp_t a;
         @(negedge clk);
         #2;
         cyc_no++;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            a = '{div_out, div_tick, div_busy, div_err, div_cur};
            vecs++;
            if (a !== x) begin
               bad++;
               $display("FAIL cyc%0d got out=%b tick=%b busy=%b err=%b cur=%0d exp out=%b tick=%b busy=%b err=%b cur=%0d",
                        cyc_no, a.out, a.tick, a.busy, a.err, a.cur,
                        x.out, x.tick, x.busy, x.err, x.cur);
            end
         end
      end
   end

   initial begin
      int r;
      repeat (2) cyc(1, 1, 0, 0);
      repeat (20) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 5);
      repeat (30) cyc(0, 1, 0, 0);
      repeat (2) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 7);
      cyc(0, 1, 1, 4);
      repeat (20) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 1);
      repeat (10) cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 9);
      cyc(0, 0, 0, 0);
      repeat (25) cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 6);
      cyc(0, 0, 0, 0);
      repeat (15) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 255);
      repeat (700) cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (6) cyc(0, 1, 0, 0);
      repeat (4000) begin
         case ($urandom % 10)
            0:       r = int'($urandom % 2);
            1:       r = int'($urandom_range(2, 255));
            default: r = int'($urandom_range(2, 12));
         endcase
         cyc(($urandom % 600) == 0, ($urandom % 25) != 0, ($urandom % 8) == 0, r);
      end
      @(negedge clk);
      #3;
      vecs++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d entries left, exp 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

endmodule
